// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter sharing one 4-bit FIFO among four producers
// Grants at most one nibble per cycle and never issues a write that could land in a full FIFO.
module fifo_wr_arbiter #(
    parameter int BUF_WIDTH = 3,
    parameter int BUF_SIZE  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         req_i,
    input  logic [15:0]        req_data_i,
    input  logic [BUF_WIDTH:0] fifo_count_i,
    output logic [3:0]         ack_o,
    output logic               fifo_wr_en_o,
    output logic [3:0]         fifo_buf_in_o,
    output logic [1:0]         grant_id_o,
    output logic [7:0]         stall_cnt_o
);

    localparam logic [BUF_WIDTH+1:0] SIZE_W = BUF_SIZE[BUF_WIDTH+1:0];

    logic [3:0]           ack_q, ack_d;
    logic                 wr_en_q, wr_en_d;
    logic [3:0]           buf_in_q, buf_in_d;
    logic [1:0]           grant_id_q, grant_id_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [7:0]           stall_q, stall_d;

    logic [3:0]           elig;
    logic [BUF_WIDTH+1:0] occupancy;
    logic                 room;
    logic                 found;
    logic [1:0]           sel;
    logic [1:0]           idx;

    // The just-acked requester still shows req high with its old nibble, so mask it out.
    assign elig      = req_i & ~ack_q;
    // Count the write already in flight; reads are ignored so this errs toward stalling.
    assign occupancy = {1'b0, fifo_count_i} + {{(BUF_WIDTH+1){1'b0}}, wr_en_q};
    assign room      = occupancy < SIZE_W;

    always_comb begin
        found = 1'b0;
        sel   = rr_ptr_q;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        ack_d      = 4'b0000;
        wr_en_d    = 1'b0;
        buf_in_d   = buf_in_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        stall_d    = stall_q;
        if (found && room) begin
            ack_d      = 4'b0001 << sel;
            wr_en_d    = 1'b1;
            buf_in_d   = req_data_i[{sel, 2'b00} +: 4];
            grant_id_d = sel;
            rr_ptr_d   = sel + 2'd1;
        end
        if (found && !room && stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q      <= 4'b0000;
            wr_en_q    <= 1'b0;
            buf_in_q   <= 4'h0;
            grant_id_q <= 2'd0;
            rr_ptr_q   <= 2'd0;
            stall_q    <= 8'd0;
        end else begin
            ack_q      <= ack_d;
            wr_en_q    <= wr_en_d;
            buf_in_q   <= buf_in_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            stall_q    <= stall_d;
        end
    end

    assign ack_o         = ack_q;
    assign fifo_wr_en_o  = wr_en_q;
    assign fifo_buf_in_o = buf_in_q;
    assign grant_id_o    = grant_id_q;
    assign stall_cnt_o   = stall_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one 4-bit FIFO (`fifo_4bit`, `BUF_SIZE` entries) among four producers. Each cycle it picks at most one pending requester, registers that requester's nibble onto the FIFO write port, and returns a one-hot acknowledge. It never writes into a FIFO that could be full when the write lands. It also keeps a saturating count of cycles lost to back-pressure. It sits between the producer blocks and the FIFO's `wr_en`/`buf_in`/`fifo_counter` ports; the FIFO read side is not touched.

## Interface
- `BUF_WIDTH`, 3: FIFO address width; must match the FIFO instance.
- `BUF_SIZE`, 8: FIFO depth, equal to 2^`BUF_WIDTH`.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: bit i high means requester i has a nibble pending.
- `req_data` in 16: requester i's nibble on bits [4i+3:4i].
- `fifo_count` in `BUF_WIDTH`+1: the FIFO's `fifo_counter` output.
- `ack` out 4: registered one-hot pulse; bit i means requester i's nibble was accepted.
- `fifo_wr_en` out 1: registered; drives the FIFO `wr_en`.
- `fifo_buf_in` out 4: registered; drives the FIFO `buf_in`.
- `grant_id` out 2: registered index of the most recent grant.
- `stall_cnt` out 8: saturating count of back-pressure cycles.

## Operation
- Eligible set: `elig = req & ~ack`.
  - The requester acknowledged in this cycle is masked out.
  - That stops its already-captured nibble from being granted a second time.
- Space check: `room = (fifo_count + fifo_wr_en) < BUF_SIZE`.
  - Compute the sum at `BUF_WIDTH`+2 bits so it cannot overflow.
  - `fifo_wr_en` counts the write already issued but not yet applied.
  - Simultaneous FIFO reads are ignored, so the check is conservative and can never overflow the FIFO.
- Grant condition: `elig != 0 && room`.
  - Selected index = first set bit of `elig`, searching `rr_ptr`, `rr_ptr`+1, … modulo 4.
- On a grant, at the clock edge:
  - `fifo_wr_en <= 1`
  - `fifo_buf_in <=` nibble of the selected requester
  - `ack <=` one-hot of the selected requester
  - `grant_id <=` selected index
  - `rr_ptr <=` (selected index + 1) mod 4
- No grant: `fifo_wr_en <= 0`, `ack <= 0`. `fifo_buf_in`, `grant_id` and `rr_ptr` hold.
- Stall: when `elig != 0 && !room`, `stall_cnt <= stall_cnt + 1`, saturating at 255.
- Producer rule: hold `req` high with stable data until `ack[i]` is seen. In the cycle `ack[i]` is high, either drop `req[i]` or present the next nibble.
- `rst` (synchronous), including mid-operation:
  - All outputs go to 0 and `rr_ptr` goes to 0.
  - A write registered in the same cycle is cancelled; `fifo_wr_en` is 0 on the following cycle.
  - No `ack` is issued for that write.

## Timing
- Latency from request to acknowledge and FIFO write is one clock.
  - `req` is sampled at edge n.
  - `ack`, `fifo_wr_en` and `fifo_buf_in` are valid during cycle n+1.
  - The FIFO captures the nibble at edge n+2.
- Throughput is one nibble per cycle while several requesters are active.
- A single requester gets at most one grant every two cycles, because of the ack mask.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,…, with no requester skipped.
- Near full: with `fifo_count = BUF_SIZE-1` and `fifo_wr_en = 1`, no grant is issued. Granting resumes the cycle after `fifo_count` drops.
- `rr_ptr` wraps from 3 to 0.
- Reset values of all outputs are 0.

## Test plan
- Single requester, FIFO empty: `req=0001`, `data[3:0]=0xA` at edge 1 -> cycle 2 shows `ack=0001`, `fifo_wr_en=1`, `fifo_buf_in=0xA`, `grant_id=0`; cycle 3 shows `fifo_wr_en=0` even though `req` is still high.
- All four requesting with data 0x1/0x2/0x3/0x4, re-presented after each ack -> grants alternate 0,1,2,3,0…; the FIFO receives 1,2,3,4,1…; `grant_id` wraps from 3 to 0.
- Fill: requester 2 streams with no reads -> exactly 8 writes, `fifo_count=8`, then no further `fifo_wr_en`; `stall_cnt` increments every blocked cycle; one FIFO read lets the next write through the cycle after `fifo_count=7`.
- Boundary: `fifo_count=7` with a write in flight -> no grant that cycle; no FIFO overflow and no lost nibble.
- Saturation: hold the FIFO full with `req=1111` for 300 cycles -> `stall_cnt=255` and holds.
- Reset mid-stream: assert `rst` for one cycle during continuous grants -> next cycle `ack=0`, `fifo_wr_en=0`, `grant_id=0`, `stall_cnt=0`; the first grant after release goes to the lowest-indexed eligible requester.
